// File: rtl/dma_tile_requester.sv
// Splits one tile descriptor into DMA chunk requests of at most CHUNK_BYTES and pulses tile_done once all chunks complete.
// Optional latency counter on tile_cycles is built only when DMA_REQ_PERF_EN is defined.
module dma_tile_requester #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CHUNK_BYTES  = 4096,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  issue_valid,
  output logic [ADDR_WIDTH-1:0] issue_base_addr,
  output logic [LEN_WIDTH-1:0]  issue_length,
  input  logic                  issue_ready,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  input  logic                  done_valid,
  input  logic [TAG_WIDTH-1:0]  done_tag,
  output logic                  tile_done,
  output logic [LEN_WIDTH-1:0]  tile_chunks,
  output logic [TAG_WIDTH-1:0]  tile_first_tag,
  output logic                  busy,
  output logic                  err_spurious_done,
  output logic [31:0]           tile_cycles
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [LEN_WIDTH-1:0] CHUNK_LEN = LEN_WIDTH'(CHUNK_BYTES);
  localparam logic [IW-1:0]        INF_CAP   = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  issued;
  logic [IW-1:0]         inflight;
  logic [LEN_WIDTH-1:0]  chunk_len;
  logic                  first_cap;
  logic                  desc_fire, issue_fire, done_ok, done_spur, enter_done;
  logic                  unused_done_tag;

  // Completion tags are not matched against issued chunks.
  assign unused_done_tag = ^done_tag;

  assign chunk_len       = (remaining < CHUNK_LEN) ? remaining : CHUNK_LEN;
  assign issue_base_addr = cur_addr;
  assign issue_length    = chunk_len;
  assign busy            = (state != S_IDLE);

  assign desc_fire  = desc_ready && desc_valid;
  assign issue_fire = issue_valid && issue_ready;
  assign done_ok    = done_valid && (inflight != '0);
  assign done_spur  = done_valid && (inflight == '0);
  assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    desc_ready  = 1'b0;
    issue_valid = 1'b0;
    tile_done   = 1'b0;
    case (state)
      S_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) state_nxt = (desc_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        issue_valid = (inflight < INF_CAP);
        if (issue_valid && issue_ready && (remaining == chunk_len)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        tile_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr          <= '0;
      remaining         <= '0;
      issued            <= '0;
      inflight          <= '0;
      first_cap         <= 1'b0;
      tile_first_tag    <= '0;
      tile_chunks       <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      if (desc_fire) begin
        cur_addr  <= desc_addr;
        remaining <= desc_len;
        issued    <= '0;
      end else if (issue_fire) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(chunk_len);
        remaining <= remaining - chunk_len;
        issued    <= issued + LEN_WIDTH'(1);
      end

      case ({issue_fire, done_ok})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase

      // The engine presents the tag one cycle after the handshake it belongs to.
      first_cap <= issue_fire && (issued == '0);
      if (first_cap) tile_first_tag <= issue_tag;

      // A zero-length tile enters DONE on the accept edge, before issued is cleared.
      if (enter_done) tile_chunks <= desc_fire ? '0 : issued;

      if (done_spur) err_spurious_done <= 1'b1;
    end
  end

`ifdef DMA_REQ_PERF_EN
  logic [31:0] perf_cnt, perf_nxt;

  always_comb begin
    perf_nxt = perf_cnt;
    if (desc_fire)                     perf_nxt = '0;
    else if (busy && (perf_cnt != '1)) perf_nxt = perf_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      tile_cycles <= '0;
    end else begin
      perf_cnt <= perf_nxt;
      if (enter_done) tile_cycles <= perf_nxt;
    end
  end
`else
  assign tile_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_tile_requester.sv
// Directed bench for dma_tile_requester with a fixed-latency DMA engine model (MAX_INFLIGHT=2).
module tb_dma_tile_requester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_addr, desc_len;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_base_addr, issue_length;
  logic [7:0]  issue_tag = 8'h00;
  logic        done_valid;
  logic        done_eng = 1'b0;
  logic        spur_done;
  logic [7:0]  done_tag = 8'h00;
  logic        tile_done, busy, err_spurious_done;
  logic [31:0] tile_chunks, tile_cycles;
  logic [7:0]  tile_first_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign done_valid = done_eng | spur_done;

  dma_tile_requester #(
    .ADDR_WIDTH  (32),
    .LEN_WIDTH   (32),
    .TAG_WIDTH   (8),
    .CHUNK_BYTES (4096),
    .MAX_INFLIGHT(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_addr        (desc_addr),
    .desc_len         (desc_len),
    .issue_valid      (issue_valid),
    .issue_base_addr  (issue_base_addr),
    .issue_length     (issue_length),
    .issue_ready      (issue_ready),
    .issue_tag        (issue_tag),
    .done_valid       (done_valid),
    .done_tag         (done_tag),
    .tile_done        (tile_done),
    .tile_chunks      (tile_chunks),
    .tile_first_tag   (tile_first_tag),
    .busy             (busy),
    .err_spurious_done(err_spurious_done),
    .tile_cycles      (tile_cycles)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          hs_edge;
    logic [7:0]  tag;
  } hs_t;

  hs_t        hs_log[$];
  int         due_q[$];
  int         cyc = 0;
  int         lat = 1;
  int         tb_inflight = 0;
  int         max_inflight = 0;
  int         last_done_edge = 0;
  logic [7:0] tag_ctr = 8'h40;
  logic [7:0] tag_pend = 8'h00;

  // Engine model: records handshakes at the edge, schedules completion lat edges later.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      due_q.delete();
      tb_inflight = 0;
    end else begin
      if (done_eng) tb_inflight--;
      if (issue_valid && issue_ready) begin
        hs_log.push_back('{issue_base_addr, issue_length, cyc, tag_ctr});
        tag_pend = tag_ctr;
        tag_ctr++;
        due_q.push_back(cyc + lat);
        tb_inflight++;
      end
      if (tb_inflight > max_inflight) max_inflight = tb_inflight;
    end
  end

  always @(negedge clk) begin
    issue_tag = tag_pend;
    done_tag  = tag_pend;
    done_eng  = rst_n && (due_q.size() > 0) && (due_q[0] == cyc + 1);
    if (done_eng) begin
      void'(due_q.pop_front());
      last_done_edge = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input int n);
`ifdef DMA_REQ_PERF_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // Offer a descriptor at the current negedge; returns the accept edge, ends on the following negedge.
  task automatic send_desc(input logic [31:0] addr, input logic [31:0] len, output int t);
    desc_valid = 1'b1;
    desc_addr  = addr;
    desc_len   = len;
    @(posedge clk);
    @(negedge clk);
    t          = cyc;
    desc_valid = 1'b0;
  endtask

  task automatic wait_tile(input int budget, output int e);
    logic seen;
    seen = 1'b0;
    e    = -1;
    for (int i = 0; i < budget; i++) begin
      if (tile_done) begin
        seen = 1'b1;
        e    = cyc;
        break;
      end
      @(negedge clk);
    end
    check("tile_done_seen", seen, 1'b1);
  endtask

  task automatic check_log(input string tag, input int i, input logic [31:0] addr, input logic [31:0] len);
    if (hs_log.size() > i) begin
      check({tag, "_addr"}, hs_log[i].addr, addr);
      check({tag, "_len"}, hs_log[i].len, len);
    end else begin
      check({tag, "_present"}, hs_log.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e;
    desc_valid  = 1'b0;
    desc_addr   = '0;
    desc_len    = '0;
    issue_ready = 1'b1;
    spur_done   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_spurious_done, 1'b0);
    check("rst_desc_ready", desc_ready, 1'b1);
    check("rst_tile_chunks", tile_chunks, 32'd0);
    check("rst_first_tag", tile_first_tag, 8'd0);
    check("rst_tile_cycles", tile_cycles, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 10000 bytes at 0x1000 -> 4096, 4096, 1808 on consecutive edges
    lat = 1;
    hs_log.delete();
    send_desc(32'h1000, 32'd10000, t);
    check("t1_valid_after_accept", issue_valid, 1'b1);
    wait_tile(50, e);
    check("t1_nchunks_logged", hs_log.size(), 3);
    check_log("t1_c0", 0, 32'h1000, 32'd4096);
    check_log("t1_c1", 1, 32'h2000, 32'd4096);
    check_log("t1_c2", 2, 32'h3000, 32'd1808);
    if (hs_log.size() == 3) begin
      check("t1_edge0", hs_log[0].hs_edge, t + 1);
      check("t1_edge2", hs_log[2].hs_edge, t + 3);
      check("t1_first_tag", tile_first_tag, hs_log[0].tag);
    end
    check("t1_done_edge", e, t + 5);
    check("t1_tile_chunks", tile_chunks, 32'd3);
    check("t1_tile_cycles", tile_cycles, exp_cycles(5));
    @(negedge clk);
    check("t1_desc_ready_after", desc_ready, 1'b1);
    check("t1_done_pulse_once", tile_done, 1'b0);

    // zero-length tile
    hs_log.delete();
    send_desc(32'h5000, 32'd0, t);
    check("t2_tile_done", tile_done, 1'b1);
    check("t2_no_issue", issue_valid, 1'b0);
    check("t2_tile_chunks", tile_chunks, 32'd0);
    check("t2_tile_cycles", tile_cycles, exp_cycles(0));
    @(negedge clk);
    check("t2_desc_ready", desc_ready, 1'b1);
    check("t2_nothing_logged", hs_log.size(), 0);

    // back-pressure: issue_ready low for 5 cycles after the first chunk
    lat = 3;
    hs_log.delete();
    send_desc(32'h8000, 32'd12288, t);
    @(negedge clk);
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", issue_valid, 1'b1);
      check("t3_hold_addr", issue_base_addr, 32'h9000);
      check("t3_hold_len", issue_length, 32'd4096);
      @(negedge clk);
    end
    issue_ready = 1'b1;
    wait_tile(100, e);
    check("t3_nchunks_logged", hs_log.size(), 3);
    check_log("t3_c0", 0, 32'h8000, 32'd4096);
    check_log("t3_c1", 1, 32'h9000, 32'd4096);
    check_log("t3_c2", 2, 32'hA000, 32'd4096);
    if (hs_log.size() == 3) check("t3_resume_edge", hs_log[1].hs_edge, t + 7);
    check("t3_tile_chunks", tile_chunks, 32'd3);
    @(negedge clk);

    // inflight cap of 2 with a 20-cycle engine
    lat = 20;
    max_inflight = 0;
    hs_log.delete();
    send_desc(32'h0, 32'd20480, t);
    wait_tile(400, e);
    check("t4_max_inflight", max_inflight, 2);
    check("t4_nchunks_logged", hs_log.size(), 5);
    check_log("t4_c4", 4, 32'h4000, 32'd4096);
    check("t4_done_after_last", e, last_done_edge + 1);
    check("t4_tile_chunks", tile_chunks, 32'd5);
    check("t4_no_err", err_spurious_done, 1'b0);
    @(negedge clk);

    // spurious completion while idle
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("t5_err_set", err_spurious_done, 1'b1);
    check("t5_still_idle", busy, 1'b0);
    lat = 1;
    hs_log.delete();
    send_desc(32'h100, 32'd4096, t);
    wait_tile(50, e);
    check_log("t5_c0", 0, 32'h100, 32'd4096);
    check("t5_tile_chunks", tile_chunks, 32'd1);
    check("t5_err_sticky", err_spurious_done, 1'b1);
    @(negedge clk);

    // reset while draining, then a fresh tile
    lat = 20;
    send_desc(32'h3000, 32'd4096, t);
    @(negedge clk);
    check("t6_in_drain_busy", busy, 1'b1);
    check("t6_in_drain_no_issue", issue_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_desc_ready", desc_ready, 1'b1);
    check("t6_rst_err", err_spurious_done, 1'b0);
    check("t6_rst_tile_chunks", tile_chunks, 32'd0);
    check("t6_rst_first_tag", tile_first_tag, 8'd0);
    check("t6_rst_tile_cycles", tile_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lat = 1;
    hs_log.delete();
    send_desc(32'h2000, 32'd8192, t);
    wait_tile(50, e);
    check("t6_done_edge", e, t + 4);
    check("t6_tile_chunks", tile_chunks, 32'd2);
    check("t6_tile_cycles", tile_cycles, exp_cycles(4));
    check_log("t6_c1", 1, 32'h3000, 32'd4096);
    if (hs_log.size() > 0) check("t6_first_tag", tile_first_tag, hs_log[0].tag);
    check("t6_no_err", err_spurious_done, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
